// File: rtl/fsqrt_arbiter.sv
// rtl/fsqrt_arbiter.sv - round-robin sharing of one pipelined fsqrt unit among N requesters
// Optional perf counters (perf_issue/perf_stall) enabled by defining FSQRT_ARB_PERF_EN.
module fsqrt_arbiter #(
    parameter int N   = 4,
    parameter int LAT = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [N-1:0]      req_valid,
    input  logic [32*N-1:0]   req_data,
    output logic [N-1:0]      req_ready,
    input  logic              flush,
    output logic [31:0]       sq_a,
    input  logic [31:0]       sq_result,
    output logic [N-1:0]      rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              busy
`ifdef FSQRT_ARB_PERF_EN
    ,
    output logic [31:0]       perf_issue,
    output logic [31:0]       perf_stall
`endif
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] grant_id;
    logic [IDW:0]   idx;
    logic           grant_any;
    logic           xfer;
    logic [LAT-1:0] vld_q;
    logic [IDW-1:0] id_q [LAT];

    // Scan from the highest offset down so the last hit is the first index after rr_ptr.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        idx       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(N)) begin
                idx = idx - (IDW+1)'(N);
            end
            if (req_valid[idx[IDW-1:0]]) begin
                grant_any = 1'b1;
                grant_id  = idx[IDW-1:0];
            end
        end
    end

    // Holding reset also masks the combinational grant so every output reads zero.
    assign xfer = grant_any & ~flush & rstn;

    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign sq_a = xfer ? req_data[32*grant_id +: 32] : 32'h0;

    assign rr_ptr_d = !xfer                        ? rr_ptr_q :
                      (grant_id == IDW'(N - 1))    ? '0       :
                                                     grant_id + 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr_q <= '0;
            vld_q    <= '0;
            for (int s = 0; s < LAT; s++) begin
                id_q[s] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            vld_q[0] <= xfer;
            id_q[0]  <= grant_id;
            for (int s = 1; s < LAT; s++) begin
                vld_q[s] <= vld_q[s-1];
                id_q[s]  <= id_q[s-1];
            end
            if (flush) begin
                vld_q <= '0;
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (vld_q[LAT-1]) begin
            rsp_valid[id_q[LAT-1]] = 1'b1;
        end
    end

    assign rsp_data = sq_result;
    assign busy     = |vld_q;

`ifdef FSQRT_ARB_PERF_EN
    logic [31:0] perf_issue_q, perf_stall_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_issue_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (xfer) begin
                perf_issue_q <= perf_issue_q + 32'd1;
            end
            if (|(req_valid & ~req_ready)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_issue = perf_issue_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_fsqrt_arbiter.sv
// tb/tb_fsqrt_arbiter.sv - directed and randomized self-checking bench for fsqrt_arbiter
module tb_fsqrt_arbiter;
    localparam int N   = 4;
    localparam int LAT = 2;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    req_valid;
    logic [32*N-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            flush;
    logic [31:0]     sq_a;
    logic [31:0]     sq_result;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_data;
    logic            busy;
`ifdef FSQRT_ARB_PERF_EN
    logic [31:0]     perf_issue, perf_stall;
`endif

    int chk = 0;
    int err = 0;

    always #5 clk = ~clk;

    fsqrt_arbiter #(.N(N), .LAT(LAT)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .flush(flush), .sq_a(sq_a), .sq_result(sq_result),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
`ifdef FSQRT_ARB_PERF_EN
        , .perf_issue(perf_issue), .perf_stall(perf_stall)
`endif
    );

    // Stand-in for the sqrt datapath: exact for a few squares, arbitrary mix otherwise.
    function automatic logic [31:0] unit_f(input logic [31:0] a);
        case (a)
            32'h3F800000: return 32'h3F800000;
            32'h40800000: return 32'h40000000;
            32'h41100000: return 32'h40400000;
            32'h41800000: return 32'h40800000;
            default:      return {a[15:0], a[31:16]} ^ 32'h1234_5678;
        endcase
    endfunction

    logic [31:0] upipe [LAT];
    always @(posedge clk) begin
        upipe[0] <= unit_f(sq_a);
        for (int s = 1; s < LAT; s++) upipe[s] <= upipe[s-1];
    end
    assign sq_result = upipe[LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
    } op_t;

    op_t          inflight[$];
    int           rr_m = 0;
    int           cyc  = 0;
    logic [N-1:0] granted_m = '0;

    // Reference model: scheduled-response queue plus round-robin pointer, evaluated mid-cycle.
    always @(negedge clk) begin
        logic [N-1:0] exp_ready, exp_rsp;
        logic [31:0]  exp_a;
        logic         exp_busy;
        int           g;
        cyc++;
        granted_m = '0;
        if (!rstn) begin
            inflight.delete();
            rr_m = 0;
            check("m_rst_ready", req_ready, 0);
            check("m_rst_rsp", rsp_valid, 0);
            check("m_rst_busy", busy, 0);
            check("m_rst_sq_a", sq_a, 0);
        end else begin
            exp_rsp  = '0;
            exp_busy = (inflight.size() > 0);
            if (inflight.size() > 0 && inflight[0].due == cyc) exp_rsp[inflight[0].id] = 1'b1;
            g = -1;
            if (!flush) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && req_valid[(rr_m + k) % N]) g = (rr_m + k) % N;
                end
            end
            exp_ready = '0;
            exp_a     = 32'h0;
            if (g >= 0) begin
                exp_ready[g] = 1'b1;
                exp_a        = req_data[32*g +: 32];
            end
            check("m_ready", req_ready, exp_ready);
            check("m_sq_a", sq_a, exp_a);
            check("m_rsp_valid", rsp_valid, exp_rsp);
            check("m_busy", busy, exp_busy);
            if (exp_rsp != 0) begin
                check("m_rsp_data", rsp_data, unit_f(inflight[0].data));
                void'(inflight.pop_front());
            end
            if (flush) begin
                inflight.delete();
            end else if (g >= 0) begin
                inflight.push_back('{cyc + LAT, g, exp_a});
                rr_m = (g + 1) % N;
            end
            granted_m = exp_ready;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h3F800000;
            1:       return 32'h40800000;
            2:       return 32'h41100000;
            3:       return 32'h41800000;
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] op2  [4] = '{32'h41800000, 32'h41100000, 32'h40800000, 32'h3F800000};
    logic [31:0] res2 [4] = '{32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};

    initial begin
        req_valid = '0;
        req_data  = '0;
        flush     = 1'b0;
        rstn      = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // Single op: grant same cycle, result LAT later.
        req_valid = 4'b0001;
        req_data[31:0] = 32'h40800000;
        @(negedge clk);
        check("t1_ready", req_ready, 4'b0001);
        check("t1_sq_a", sq_a, 32'h40800000);
        check("t1_busy0", busy, 0);
        tick(); req_valid = '0;
        @(negedge clk);
        check("t1_busy1", busy, 1);
        check("t1_rsp_early", rsp_valid, 0);
        tick();
        @(negedge clk);
        check("t1_rsp", rsp_valid, 4'b0001);
        check("t1_data", rsp_data, 32'h40000000);
        check("t1_busy2", busy, 1);
        tick();
        @(negedge clk);
        check("t1_busy3", busy, 0);
        check("t1_rsp_after", rsp_valid, 0);

        // Full load from reset: rotating grants, in-order one-hot responses.
        tick(); rstn = 1'b0;
        tick(); rstn = 1'b1;
        for (int i = 0; i < N; i++) req_data[32*i +: 32] = op2[i];
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("t2_grant%0d", k), req_ready, 32'(1 << (k % 4)));
            if (k >= 2) begin
                check($sformatf("t2_rsp%0d", k), rsp_valid, 32'(1 << ((k - 2) % 4)));
                check($sformatf("t2_data%0d", k), rsp_data, res2[(k - 2) % 4]);
            end
            tick();
        end
        req_valid = '0;
        repeat (3) tick();

        // Pointer behaviour after granting requester 1.
        rstn = 1'b0;
        tick(); rstn = 1'b1;
        req_valid = 4'b0010;
        @(negedge clk); check("t3_g1", req_ready, 4'b0010);
        tick(); req_valid = 4'b0011;
        @(negedge clk); check("t3_g0", req_ready, 4'b0001);
        tick();
        @(negedge clk); check("t3_g1b", req_ready, 4'b0010);
        tick(); req_valid = 4'b1011;
        @(negedge clk); check("t3_g3", req_ready, 4'b1000);
        tick();
        @(negedge clk); check("t3_g0b", req_ready, 4'b0001);
        tick(); req_valid = '0;
        repeat (3) tick();

        // Flush kills in-flight op and blocks the grant in the flush cycle.
        req_valid = 4'b0010;
        @(negedge clk); check("t4_g1", req_ready, 4'b0010);
        tick(); req_valid = 4'b0100; flush = 1'b1;
        @(negedge clk);
        check("t4_flush_ready", req_ready, 0);
        check("t4_flush_sq_a", sq_a, 0);
        check("t4_flush_busy", busy, 1);
        tick(); flush = 1'b0;
        @(negedge clk);
        check("t4_busy_after", busy, 0);
        check("t4_rsp_t2", rsp_valid, 0);
        check("t4_g2", req_ready, 4'b0100);
        tick(); req_valid = '0;
        @(negedge clk); check("t4_rsp_t3", rsp_valid, 0);
        repeat (3) tick();

        // Reset mid-flight: outputs drop at once, killed ops never respond.
        req_valid = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("t5_g%0d", k), req_ready, 32'(1 << k));
            tick();
            req_valid[k] = 1'b0;
        end
        rstn = 1'b0;
        req_valid = 4'b0001;
        req_data[31:0] = 32'h41100000;
        #1;
        check("t5_async_ready", req_ready, 0);
        check("t5_async_rsp", rsp_valid, 0);
        check("t5_async_busy", busy, 0);
        check("t5_async_sq_a", sq_a, 0);
        tick(); rstn = 1'b1;
        @(negedge clk);
        check("t5_new_grant", req_ready, 4'b0001);
        check("t5_rsp_r0", rsp_valid, 0);
        tick(); req_valid = '0;
        @(negedge clk); check("t5_rsp_r1", rsp_valid, 0);
        tick();
        @(negedge clk);
        check("t5_rsp_r2", rsp_valid, 4'b0001);
        check("t5_data", rsp_data, 32'h40400000);
        tick();

`ifdef FSQRT_ARB_PERF_EN
        begin
            logic [31:0] pi0, ps0;
            repeat (2) tick();
            pi0 = perf_issue;
            ps0 = perf_stall;
            req_valid = '1;
            repeat (10) tick();
            req_valid = '0;
            @(negedge clk);
            check("t6_issue", perf_issue - pi0, 10);
            check("t6_stall", perf_stall - ps0, 10);
            tick(); flush = 1'b1;
            tick(); flush = 1'b0;
            @(negedge clk);
            check("t6_issue_flush", perf_issue - pi0, 10);
            check("t6_stall_flush", perf_stall - ps0, 10);
            tick();
        end
`endif

        // Randomized traffic with flushes and occasional reset pulses.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            tick();
            rstn  = ($urandom_range(0, 299) != 0);
            flush = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < N; i++) begin
                if (granted_m[i] || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    req_data[32*i +: 32] = pick();
                end
            end
        end
        rstn      = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        repeat (LAT + 3) tick();

        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end
endmodule
